// File: rtl/alarm_pkg.sv
// Shared types and constants for the time-set controller: FSM states,
// edit_field encodings and BCD digit limits.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_EDIT_HOUR = 2'd1,
        ST_EDIT_MIN  = 2'd2,
        ST_COMMIT    = 2'd3
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    localparam int unsigned BCD_UNITS_MAX  = 9;
    localparam int unsigned MIN_TENS_MAX   = 5;
    localparam int unsigned HOUR_TENS_MAX  = 2;
    localparam int unsigned HOUR_UNITS_TOP = 3;

endpackage

// File: rtl/bcd_pair_inc.sv
// Two-digit BCD incrementer that wraps to 00 after TENS_MAX:UNITS_TOP
// (23 for hours, 59 for minutes).
module bcd_pair_inc
    import alarm_pkg::*;
#(
    parameter int unsigned TENS_MAX  = 5,
    parameter int unsigned UNITS_TOP = 9,
    parameter int unsigned TENS_W    = 3
) (
    input  logic [TENS_W-1:0] tens_i,
    input  logic [3:0]        units_i,
    output logic [TENS_W-1:0] tens_o,
    output logic [3:0]        units_o
);

    always_comb begin
        tens_o  = tens_i;
        units_o = units_i + 4'd1;
        if (tens_i == TENS_W'(TENS_MAX) && units_i == 4'(UNITS_TOP)) begin
            tens_o  = '0;
            units_o = '0;
        end else if (units_i == 4'(BCD_UNITS_MAX)) begin
            tens_o  = tens_i + TENS_W'(1);
            units_o = '0;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-set controller: RUN -> EDIT_HOUR -> EDIT_MIN -> COMMIT with idle timeout.
// Optional field blinking is built only when BLINK_EN_EN is defined.
module time_set_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned BLINK_HALF = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_u_min,
    input  logic [2:0] cur_z_min,
    input  logic [3:0] cur_u_hour,
    input  logic [1:0] cur_z_hour,
    output logic       count_en,
    output logic       sel_program,
    output logic       load,
    output logic [3:0] set_u_min,
    output logic [2:0] set_z_min,
    output logic [3:0] set_u_hour,
    output logic [1:0] set_z_hour,
    output logic [1:0] edit_field,
    output logic       blink
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    state_e        state_q;
    logic [IW-1:0] idle_q;
    logic          load_q;
    logic [3:0]    set_u_min_q;
    logic [2:0]    set_z_min_q;
    logic [3:0]    set_u_hour_q;
    logic [1:0]    set_z_hour_q;

    logic [3:0]    hour_u_d;
    logic [1:0]    hour_z_d;
    logic [3:0]    min_u_d;
    logic [2:0]    min_z_d;
    logic          timeout_hit;

    bcd_pair_inc #(
        .TENS_MAX (HOUR_TENS_MAX),
        .UNITS_TOP(HOUR_UNITS_TOP),
        .TENS_W   (2)
    ) u_hour_inc (
        .tens_i (set_z_hour_q),
        .units_i(set_u_hour_q),
        .tens_o (hour_z_d),
        .units_o(hour_u_d)
    );

    bcd_pair_inc #(
        .TENS_MAX (MIN_TENS_MAX),
        .UNITS_TOP(BCD_UNITS_MAX),
        .TENS_W   (3)
    ) u_min_inc (
        .tens_i (set_z_min_q),
        .units_i(set_u_min_q),
        .tens_o (min_z_d),
        .units_o(min_u_d)
    );

    // The edit state lasts exactly TIMEOUT idle cycles, counting the entry cycle.
    assign timeout_hit = (idle_q == IW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            idle_q       <= '0;
            load_q       <= 1'b0;
            set_u_min_q  <= '0;
            set_z_min_q  <= '0;
            set_u_hour_q <= '0;
            set_z_hour_q <= '0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (btn_mode) begin
                        set_u_min_q  <= cur_u_min;
                        set_z_min_q  <= cur_z_min;
                        set_u_hour_q <= cur_u_hour;
                        set_z_hour_q <= cur_z_hour;
                        idle_q       <= '0;
                        state_q      <= ST_EDIT_HOUR;
                    end
                end
                ST_EDIT_HOUR: begin
                    if (btn_mode) begin
                        idle_q  <= '0;
                        state_q <= ST_EDIT_MIN;
                    end else if (btn_inc) begin
                        set_u_hour_q <= hour_u_d;
                        set_z_hour_q <= hour_z_d;
                        idle_q       <= '0;
                    end else if (timeout_hit) begin
                        idle_q  <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        idle_q <= idle_q + IW'(1);
                    end
                end
                ST_EDIT_MIN: begin
                    if (btn_mode) begin
                        idle_q  <= '0;
                        load_q  <= 1'b1;
                        state_q <= ST_COMMIT;
                    end else if (btn_inc) begin
                        set_u_min_q <= min_u_d;
                        set_z_min_q <= min_z_d;
                        idle_q      <= '0;
                    end else if (timeout_hit) begin
                        idle_q  <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        idle_q <= idle_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        edit_field = FIELD_NONE;
        if (state_q == ST_EDIT_HOUR) edit_field = FIELD_HOUR;
        else if (state_q == ST_EDIT_MIN) edit_field = FIELD_MIN;
    end

    assign count_en    = (state_q == ST_RUN);
    assign sel_program = (state_q != ST_RUN);
    assign load        = load_q;
    assign set_u_min   = set_u_min_q;
    assign set_z_min   = set_z_min_q;
    assign set_u_hour  = set_u_hour_q;
    assign set_z_hour  = set_z_hour_q;

`ifdef BLINK_EN_EN
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;
    logic          in_edit;
    logic          blink_restart;

    assign in_edit = (state_q == ST_EDIT_HOUR) || (state_q == ST_EDIT_MIN);
    // Any event that changes state or the edited value restarts with the field visible.
    assign blink_restart = !in_edit || btn_mode || btn_inc || timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_restart) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: integer hour/minute reference model,
// per-cycle compare, directed scenarios and randomized button traffic.
module tb_time_set_ctrl;

    localparam int unsigned TO = 8;
    localparam int unsigned BH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_u_min;
    logic [2:0] cur_z_min;
    logic [3:0] cur_u_hour;
    logic [1:0] cur_z_hour;
    logic       count_en;
    logic       sel_program;
    logic       load;
    logic [3:0] set_u_min;
    logic [2:0] set_z_min;
    logic [3:0] set_u_hour;
    logic [1:0] set_z_hour;
    logic [1:0] edit_field;
    logic       blink;

    time_set_ctrl #(
        .TIMEOUT   (TO),
        .BLINK_HALF(BH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_u_min  (cur_u_min),
        .cur_z_min  (cur_z_min),
        .cur_u_hour (cur_u_hour),
        .cur_z_hour (cur_z_hour),
        .count_en   (count_en),
        .sel_program(sel_program),
        .load       (load),
        .set_u_min  (set_u_min),
        .set_z_min  (set_z_min),
        .set_u_hour (set_u_hour),
        .set_z_hour (set_z_hour),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 running, 1 editing hour, 2 editing minute, 3 committing.
    int m_mode, m_hour, m_min, m_idle, m_since;
    int cur_h, cur_m;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cur(input int h, input int m);
        cur_h      = h;
        cur_m      = m;
        cur_z_hour = 2'(h / 10);
        cur_u_hour = 4'(h % 10);
        cur_z_min  = 3'(m / 10);
        cur_u_min  = 4'(m % 10);
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_hour  = 0;
        m_min   = 0;
        m_idle  = 0;
        m_since = 0;
    endtask

    task automatic model_step(input bit mode, input bit inc);
        case (m_mode)
            0: begin
                if (mode) begin
                    m_hour = cur_h; m_min = cur_m;
                    m_mode = 1; m_idle = 0; m_since = 0;
                end
            end
            1, 2: begin
                if (mode) begin
                    m_mode = m_mode + 1; m_idle = 0; m_since = 0;
                end else if (inc) begin
                    if (m_mode == 1) m_hour = (m_hour + 1) % 24;
                    else             m_min  = (m_min + 1) % 60;
                    m_idle = 0; m_since = 0;
                end else if (m_idle + 1 >= int'(TO)) begin
                    m_mode = 0;
                end else begin
                    m_idle++; m_since++;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_model();
        int exp_blink;
        exp_blink = 0;
`ifdef BLINK_EN_EN
        if (m_mode == 1 || m_mode == 2) exp_blink = (m_since / int'(BH)) % 2;
`endif
        chk("count_en",    count_en,    m_mode == 0);
        chk("sel_program", sel_program, m_mode != 0);
        chk("load",        load,        m_mode == 3);
        chk("edit_field",  edit_field,  (m_mode == 1) ? 1 : (m_mode == 2) ? 2 : 0);
        chk("set_z_hour",  set_z_hour,  m_hour / 10);
        chk("set_u_hour",  set_u_hour,  m_hour % 10);
        chk("set_z_min",   set_z_min,   m_min / 10);
        chk("set_u_min",   set_u_min,   m_min % 10);
        chk("blink",       blink,       exp_blink);
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) check_model();
    end

    task automatic step(input bit mode, input bit inc);
        btn_mode = mode;
        btn_inc  = inc;
        @(posedge clk);
        model_step(mode, inc);
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count_en"},    count_en,    1);
        chk({tag, "_sel_program"}, sel_program, 0);
        chk({tag, "_load"},        load,        0);
        chk({tag, "_edit_field"},  edit_field,  0);
        chk({tag, "_blink"},       blink,       0);
        chk({tag, "_set_hour"},    {set_z_hour, set_u_hour}, 0);
        chk({tag, "_set_min"},     {set_z_min, set_u_min},   0);
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("rst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n_min;
        bit seen_load;
        set_cur(0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("rst_init");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Entry captures the live time.
        set_cur(12, 34);
        step(1'b1, 1'b0);
        chk("entry_edit_field", edit_field, 1);
        chk("entry_count_en", count_en, 0);
        chk("entry_sel", sel_program, 1);
        chk("entry_z_hour", set_z_hour, 1);
        chk("entry_u_hour", set_u_hour, 2);
        chk("entry_z_min", set_z_min, 3);
        chk("entry_u_min", set_u_min, 4);
        set_cur(5, 5);
        step(1'b0, 1'b0);
        chk("edit_ignores_cur", {set_z_hour, set_u_hour}, 8'h12);

        // Hour increments through 19->20 up to 22, then wraps 23 -> 00.
        repeat (10) step(1'b0, 1'b1);
        chk("hour_22", {set_z_hour, set_u_hour}, 8'h22);
        step(1'b0, 1'b1);
        chk("hour_23", {set_z_hour, set_u_hour}, 8'h23);
        step(1'b0, 1'b1);
        chk("hour_wrap_00", {set_z_hour, set_u_hour}, 8'h00);
        chk("hour_wrap_min", {set_z_min, set_u_min}, 7'h34);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Minute wrap with no hour carry, then commit.
        set_cur(7, 59);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("min_edit_field", edit_field, 2);
        step(1'b0, 1'b1);
        chk("min_wrap", {set_z_min, set_u_min}, 7'h00);
        chk("min_wrap_hour", {set_z_hour, set_u_hour}, 8'h07);
        step(1'b1, 1'b0);
        chk("commit_load", load, 1);
        chk("commit_sel", sel_program, 1);
        chk("commit_field", edit_field, 0);
        chk("commit_set", {set_z_hour, set_u_hour, set_z_min, set_u_min}, 18'({8'h07, 7'h00}));
        step(1'b1, 1'b1);
        chk("post_commit_load", load, 0);
        chk("post_commit_count_en", count_en, 1);
        step(1'b0, 1'b1);
        chk("run_inc_ignored", {set_z_min, set_u_min}, 7'h00);

        // Timeout in EDIT_MIN.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_min = (edit_field == 2'd2) ? 1 : 0;
        seen_load = 1'b0;
        for (int i = 0; i < 20 && edit_field == 2'd2; i++) begin
            step(1'b0, 1'b0);
            if (load) seen_load = 1'b1;
            if (edit_field == 2'd2) n_min++;
        end
        chk("timeout_cycles", n_min, 8);
        chk("timeout_no_load", seen_load, 0);
        chk("timeout_count_en", count_en, 1);

        // Mode wins over inc; reset mid-edit discards everything.
        set_cur(15, 42);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("collide_field", edit_field, 2);
        chk("collide_hour", {set_z_hour, set_u_hour}, 8'h15);
        step(1'b0, 1'b1);
        chk("collide_min", {set_z_min, set_u_min}, 7'h43);
        do_reset();
        repeat (3) begin
            step(1'b0, 1'b0);
            chk("post_reset_load", load, 0);
        end

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0)
                set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                step($urandom_range(0, 99) < 12, $urandom_range(0, 2) == 0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
